// File: rtl/hs_rr_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ valid/ready senders into one
// single-word req/ack receiver, one latched word per transfer.
module hs_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 32,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       port_en,
  input  logic [NUM_REQ-1:0]       valid,
  output logic [NUM_REQ-1:0]       ready,
  input  logic [NUM_REQ*WIDTH-1:0] data_in,
  output logic                     req,
  input  logic                     ack,
  output logic [WIDTH-1:0]         data_out,
  output logic [IDW-1:0]           grant_id,
  output logic                     busy
);

  localparam int SW = IDW + 1;

  typedef enum logic [1:0] {IDLE, REQON, STOP} state_e;

  state_e               state_q, state_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [IDW-1:0]       grant_id_q, grant_id_d;
  logic [WIDTH-1:0]     hold_q, hold_d;

  logic [NUM_REQ-1:0]   eligible;
  logic [2*NUM_REQ-1:0] doubled;
  logic [2*NUM_REQ-1:0] rotated;
  logic [SW-1:0]        off_sel;
  logic [SW-1:0]        win_sum;
  logic [IDW-1:0]       winner;
  logic                 found;

  // Rotate the eligible set so ptr sits at bit 0; the lowest set bit is then
  // the round-robin distance from ptr to the winner.
  always_comb begin
    eligible = valid & port_en;
    doubled  = {eligible, eligible};
    rotated  = doubled >> ptr_q;
    found    = |eligible;
    off_sel  = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      if (rotated[off]) begin
        off_sel = SW'(off);
      end
    end
    win_sum = {1'b0, ptr_q} + off_sel;
    if (win_sum >= SW'(NUM_REQ)) begin
      win_sum = win_sum - SW'(NUM_REQ);
    end
    winner = win_sum[IDW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      hold_q     <= '0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_q     <= hold_d;
      grant_id_q <= grant_id_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_d     = hold_q;
    grant_id_d = grant_id_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == IDW'(i)) begin
              hold_d = data_in[i*WIDTH +: WIDTH];
            end
          end
          grant_id_d = winner;
          state_d    = REQON;
        end
      end
      REQON: begin
        if (ack) begin
          ptr_d   = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
          state_d = STOP;
        end
      end
      STOP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held, whatever the state.
  always_comb begin
    ready    = '0;
    req      = 1'b0;
    data_out = '0;
    busy     = 1'b0;
    grant_id = grant_id_q;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (found) begin
            ready[winner] = 1'b1;
          end
        end
        REQON: begin
          req  = 1'b1;
          busy = 1'b1;
          if (ack) begin
            data_out = hold_q;
          end
        end
        STOP:    busy = 1'b1;
        default: busy = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// Self-checking bench for hs_rr_arbiter: directed scenarios plus a randomized
// run scored against a transaction-level round-robin model.
module tb_hs_rr_arbiter;

  localparam int N = 4;
  localparam int W = 32;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   port_en;
  logic [N-1:0]   valid;
  logic [N-1:0]   ready;
  logic [N*W-1:0] data_in;
  logic           req;
  logic           ack;
  logic [W-1:0]   data_out;
  logic [IDW-1:0] grant_id;
  logic           busy;

  int n_cmp = 0;
  int n_err = 0;

  int         m_phase;
  int         m_ptr;
  int         m_gid;
  logic [W-1:0] m_hold;

  hs_rr_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .port_en(port_en), .valid(valid), .ready(ready),
    .data_in(data_in), .req(req), .ack(ack), .data_out(data_out),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic set_word(input int i, input logic [W-1:0] v);
    data_in[i*W +: W] = v;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    valid = '0;
    ack = 1'b0;
    port_en = '1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Winner = eligible index with the smallest forward distance from ptr.
  function automatic int model_winner(input logic [N-1:0] v, input logic [N-1:0] e, input int p);
    int best;
    int best_dist;
    int d;
    best = -1;
    best_dist = N;
    for (int i = 0; i < N; i++) begin
      if (v[i] && e[i]) begin
        d = (i - p + N) % N;
        if (d < best_dist) begin
          best_dist = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    valid = 4'b1111;
    port_en = 4'b1111;
    ack = 1'b0;
    data_in = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 0; c < 2; c++) begin
      settle();
      n_cmp++; if (ready !== 4'b0000) begin n_err++; $display("[TB] FAIL reset_ready: got %b expected 0000", ready); end
      n_cmp++; if (req !== 1'b0) begin n_err++; $display("[TB] FAIL reset_req: got %b expected 0", req); end
      n_cmp++; if (data_out !== 32'h0) begin n_err++; $display("[TB] FAIL reset_data_out: got %h expected 0", data_out); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      tick();
    end
    rst = 1'b0;
    settle();
    n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("[TB] FAIL reset_grant_id: got %0d expected 0", grant_id); end
    n_cmp++; if (ready !== 4'b0001) begin n_err++; $display("[TB] FAIL reset_first_ready: got %b expected 0001", ready); end
    tick();
  endtask

  task automatic test_single_port();
    apply_reset();
    data_in = {$urandom, $urandom, $urandom, $urandom};
    set_word(2, 32'hA5A5_0002);
    valid = 4'b0100;
    ack = 1'b1;
    settle();
    n_cmp++; if (ready !== 4'b0100) begin n_err++; $display("[TB] FAIL single_ready: got %b expected 0100", ready); end
    n_cmp++; if (req !== 1'b0) begin n_err++; $display("[TB] FAIL single_req_idle: got %b expected 0", req); end
    tick();
    valid = 4'b0000;
    settle();
    n_cmp++; if (req !== 1'b1) begin n_err++; $display("[TB] FAIL single_req: got %b expected 1", req); end
    n_cmp++; if (ready !== 4'b0000) begin n_err++; $display("[TB] FAIL single_ready_reqon: got %b expected 0000", ready); end
    n_cmp++; if (data_out !== 32'hA5A5_0002) begin n_err++; $display("[TB] FAIL single_data: got %h expected a5a50002", data_out); end
    n_cmp++; if (grant_id !== 2'd2) begin n_err++; $display("[TB] FAIL single_grant: got %0d expected 2", grant_id); end
    tick();
    settle();
    n_cmp++; if (req !== 1'b0 || busy !== 1'b1 || data_out !== 32'h0) begin n_err++; $display("[TB] FAIL single_stop: got req=%b busy=%b data=%h expected req=0 busy=1 data=0", req, busy, data_out); end
    tick();
    settle();
    n_cmp++; if (busy !== 1'b0 || req !== 1'b0) begin n_err++; $display("[TB] FAIL single_idle: got busy=%b req=%b expected 0 0", busy, req); end
    tick();
  endtask

  task automatic test_fairness();
    int e;
    apply_reset();
    for (int i = 0; i < N; i++) set_word(i, 32'hF000_0000 | 32'(i));
    valid = 4'b1111;
    ack = 1'b1;
    for (int t = 0; t < 5; t++) begin
      e = t % N;
      settle();
      n_cmp++; if (ready !== (4'b0001 << e)) begin n_err++; $display("[TB] FAIL fair_ready_%0d: got %b expected %b", t, ready, 4'b0001 << e); end
      tick();
      settle();
      n_cmp++; if (req !== 1'b1 || grant_id !== 2'(e) || data_out !== (32'hF000_0000 | 32'(e))) begin
        n_err++; $display("[TB] FAIL fair_xfer_%0d: got req=%b grant=%0d data=%h expected req=1 grant=%0d", t, req, grant_id, data_out, e);
      end
      tick();
      settle();
      n_cmp++; if (req !== 1'b0 || ready !== 4'b0000) begin n_err++; $display("[TB] FAIL fair_stop_%0d: got req=%b ready=%b expected 0 0000", t, req, ready); end
      tick();
    end
  endtask

  task automatic test_ack_stall();
    apply_reset();
    data_in = {$urandom, $urandom, $urandom, $urandom};
    set_word(1, 32'h1234_5678);
    valid = 4'b0010;
    ack = 1'b0;
    settle();
    n_cmp++; if (ready !== 4'b0010) begin n_err++; $display("[TB] FAIL stall_accept: got %b expected 0010", ready); end
    tick();
    set_word(1, 32'hDEAD_BEEF);
    valid = 4'b0011;
    for (int c = 0; c < 10; c++) begin
      settle();
      n_cmp++; if (req !== 1'b1 || data_out !== 32'h0 || ready !== 4'b0000) begin
        n_err++; $display("[TB] FAIL stall_cycle_%0d: got req=%b data=%h ready=%b expected 1 0 0000", c, req, data_out, ready);
      end
      tick();
    end
    ack = 1'b1;
    settle();
    n_cmp++; if (data_out !== 32'h1234_5678) begin n_err++; $display("[TB] FAIL stall_hold: got %h expected 12345678", data_out); end
    tick();
    ack = 1'b0;
    valid = 4'b0000;
    settle();
    n_cmp++; if (req !== 1'b0) begin n_err++; $display("[TB] FAIL stall_stop: got %b expected 0", req); end
    tick();
    valid = 4'b0110;
    settle();
    n_cmp++; if (ready !== 4'b0100) begin n_err++; $display("[TB] FAIL stall_ptr_adv: got %b expected 0100", ready); end
    tick();
  endtask

  task automatic test_mask_wrap();
    int exp_seq [3] = '{3, 1, 3};
    logic [N-1:0] seen;
    apply_reset();
    data_in = {$urandom, $urandom, $urandom, $urandom};
    valid = 4'b0100;
    ack = 1'b1;
    settle();
    n_cmp++; if (ready !== 4'b0100) begin n_err++; $display("[TB] FAIL mask_setup: got %b expected 0100", ready); end
    tick();
    valid = 4'b0000;
    tick();
    tick();
    port_en = 4'b1010;
    valid = 4'b1111;
    seen = '0;
    for (int t = 0; t < 3; t++) begin
      settle();
      seen |= ready;
      n_cmp++; if (ready !== (4'b0001 << exp_seq[t])) begin n_err++; $display("[TB] FAIL mask_ready_%0d: got %b expected %b", t, ready, 4'b0001 << exp_seq[t]); end
      tick();
      settle();
      seen |= ready;
      n_cmp++; if (grant_id !== 2'(exp_seq[t])) begin n_err++; $display("[TB] FAIL mask_grant_%0d: got %0d expected %0d", t, grant_id, exp_seq[t]); end
      tick();
      settle();
      seen |= ready;
      tick();
    end
    n_cmp++; if ((seen & 4'b0101) !== 4'b0000) begin n_err++; $display("[TB] FAIL mask_blocked: got %b expected 0000", seen & 4'b0101); end
    port_en = 4'b1111;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    data_in = {$urandom, $urandom, $urandom, $urandom};
    valid = 4'b0010;
    ack = 1'b1;
    tick();
    valid = 4'b0000;
    tick();
    tick();
    valid = 4'b0001;
    ack = 1'b0;
    settle();
    n_cmp++; if (ready !== 4'b0001) begin n_err++; $display("[TB] FAIL mid_accept: got %b expected 0001", ready); end
    tick();
    valid = 4'b0000;
    settle();
    n_cmp++; if (req !== 1'b1) begin n_err++; $display("[TB] FAIL mid_reqon: got %b expected 1", req); end
    tick();
    rst = 1'b1;
    settle();
    n_cmp++; if (req !== 1'b0 || busy !== 1'b0) begin n_err++; $display("[TB] FAIL mid_forced: got req=%b busy=%b expected 0 0", req, busy); end
    tick();
    rst = 1'b0;
    ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      n_cmp++; if (req !== 1'b0 || busy !== 1'b0) begin n_err++; $display("[TB] FAIL mid_late_ack_%0d: got req=%b busy=%b expected 0 0", c, req, busy); end
      tick();
    end
    ack = 1'b0;
    valid = 4'b0110;
    settle();
    n_cmp++; if (ready !== 4'b0010) begin n_err++; $display("[TB] FAIL mid_ptr_cleared: got %b expected 0010", ready); end
    tick();
  endtask

  task automatic test_random();
    int w;
    logic [N-1:0] e_ready;
    logic e_req;
    logic e_busy;
    logic [W-1:0] e_data;
    apply_reset();
    m_phase = 0;
    m_ptr = 0;
    m_gid = 0;
    m_hold = '0;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      valid = 4'($urandom);
      port_en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
      ack = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) set_word(i, $urandom);
      settle();
      e_ready = '0;
      e_req = 1'b0;
      e_busy = 1'b0;
      e_data = '0;
      if (!rst) begin
        if (m_phase == 0) begin
          w = model_winner(valid, port_en, m_ptr);
          if (w >= 0) e_ready = 4'b0001 << w;
        end else if (m_phase == 1) begin
          e_req = 1'b1;
          e_busy = 1'b1;
          if (ack) e_data = m_hold;
        end else begin
          e_busy = 1'b1;
        end
      end
      n_cmp++; if (ready !== e_ready) begin n_err++; $display("[TB] FAIL rand_ready_c%0d: got %b expected %b", c, ready, e_ready); end
      n_cmp++; if (req !== e_req) begin n_err++; $display("[TB] FAIL rand_req_c%0d: got %b expected %b", c, req, e_req); end
      n_cmp++; if (busy !== e_busy) begin n_err++; $display("[TB] FAIL rand_busy_c%0d: got %b expected %b", c, busy, e_busy); end
      n_cmp++; if (data_out !== e_data) begin n_err++; $display("[TB] FAIL rand_data_c%0d: got %h expected %h", c, data_out, e_data); end
      if (!rst) begin
        n_cmp++; if (grant_id !== m_gid[IDW-1:0]) begin n_err++; $display("[TB] FAIL rand_grant_c%0d: got %0d expected %0d", c, grant_id, m_gid); end
      end
      if (rst) begin
        m_phase = 0;
        m_ptr = 0;
        m_gid = 0;
        m_hold = '0;
      end else if (m_phase == 0) begin
        w = model_winner(valid, port_en, m_ptr);
        if (w >= 0) begin
          m_hold = data_in[w*W +: W];
          m_gid = w;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (ack) begin
          m_ptr = (m_gid + 1) % N;
          m_phase = 2;
        end
      end else begin
        m_phase = 0;
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    port_en = '1;
    valid = '0;
    ack = 1'b0;
    data_in = '0;
    test_reset();
    test_single_port();
    test_fairness();
    test_ack_stall();
    test_mask_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
